// File: rtl/hbmc_pkg.sv
// Shared definitions for the HyperBus controller transmit data path.
// Holds the state encoding, the RWDS mask polarity and the byte-lane positions.
package hbmc_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LATENCY = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;

  localparam logic HBMC_RWDS_MASKED = 1'b1;

  // The rising half-cycle carries the upper byte of each 16-bit word.
  localparam int RISE_MSB  = 15;
  localparam int RISE_LSB  = 8;
  localparam int FALL_MSB  = 7;
  localparam int FALL_LSB  = 0;
  localparam int STRB_RISE = 1;
  localparam int STRB_FALL = 0;
endpackage

// File: rtl/hbmc_tx_word_split.sv
// Registered mapper from a 16-bit write word to DDR byte pair, RWDS masks and OEs.
// A fill word drives zero data with both bytes masked.
module hbmc_tx_word_split
  import hbmc_pkg::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        emit,
  input  logic        fill,
  input  logic [15:0] data,
  input  logic [1:0]  strb,
  output logic [7:0]  dq_rise,
  output logic [7:0]  dq_fall,
  output logic        rwds_rise,
  output logic        rwds_fall,
  output logic        dq_oe,
  output logic        rwds_oe
);
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dq_rise   <= '0;
      dq_fall   <= '0;
      rwds_rise <= 1'b0;
      rwds_fall <= 1'b0;
      dq_oe     <= 1'b0;
      rwds_oe   <= 1'b0;
    end else if (!emit) begin
      dq_rise   <= '0;
      dq_fall   <= '0;
      rwds_rise <= 1'b0;
      rwds_fall <= 1'b0;
      dq_oe     <= 1'b0;
      rwds_oe   <= 1'b0;
    end else if (fill) begin
      dq_rise   <= '0;
      dq_fall   <= '0;
      rwds_rise <= HBMC_RWDS_MASKED;
      rwds_fall <= HBMC_RWDS_MASKED;
      dq_oe     <= 1'b1;
      rwds_oe   <= 1'b1;
    end else begin
      dq_rise   <= data[RISE_MSB:RISE_LSB];
      dq_fall   <= data[FALL_MSB:FALL_LSB];
      rwds_rise <= ~strb[STRB_RISE];
      rwds_fall <= ~strb[STRB_FALL];
      dq_oe     <= 1'b1;
      rwds_oe   <= 1'b1;
    end
  end
endmodule

// File: rtl/hbmc_tx_data_path.sv
// HyperBus transmit write-data path: latency wait, then one word per clock with
// masked filler on underrun. Optional filler counter: HBMC_TX_UNDERRUN_CNT_EN.
module hbmc_tx_data_path
  import hbmc_pkg::*;
#(
  parameter int LEN_WIDTH = 8,
  parameter int LAT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic [LAT_WIDTH-1:0] lat_cycles,
  input  logic [15:0]          s_data,
  input  logic [1:0]           s_strb,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [7:0]           dq_rise,
  output logic [7:0]           dq_fall,
  output logic                 rwds_rise,
  output logic                 rwds_fall,
  output logic                 dq_oe,
  output logic                 rwds_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
`ifdef HBMC_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]           underrun_cnt
`endif
);
  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [LAT_WIDTH-1:0] lat_cnt;
  logic                 accept;
  logic                 last_word;
  logic                 filler;

  // A start landing in the done cycle sees IDLE and is accepted, giving back-to-back bursts.
  assign accept    = (state == ST_IDLE) && start && (burst_len != '0);
  assign last_word = (state == ST_DATA) && (word_cnt == LEN_WIDTH'(1));
  assign filler    = (state == ST_DATA) && !s_valid;
  assign s_ready   = (state == ST_DATA);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          word_cnt <= burst_len;
          lat_cnt  <= lat_cycles;
          state    <= (lat_cycles != '0) ? ST_LATENCY : ST_DATA;
        end
        ST_LATENCY: begin
          lat_cnt <= lat_cnt - LAT_WIDTH'(1);
          if (lat_cnt == LAT_WIDTH'(1)) state <= ST_DATA;
        end
        ST_DATA: begin
          word_cnt <= word_cnt - LEN_WIDTH'(1);
          if (word_cnt == LEN_WIDTH'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // done lines up with the last word on the pins; busy falls one cycle later.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= last_word;
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (accept)      underrun <= 1'b0;
      else if (filler) underrun <= 1'b1;
    end
  end

`ifdef HBMC_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                                  underrun_cnt <= '0;
    else if (accept)                           underrun_cnt <= '0;
    else if (filler && underrun_cnt != 8'hFF)  underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

  hbmc_tx_word_split u_split (
    .clk       (clk),
    .arst      (arst),
    .emit      (state == ST_DATA),
    .fill      (!s_valid),
    .data      (s_data),
    .strb      (s_strb),
    .dq_rise   (dq_rise),
    .dq_fall   (dq_fall),
    .rwds_rise (rwds_rise),
    .rwds_fall (rwds_fall),
    .dq_oe     (dq_oe),
    .rwds_oe   (rwds_oe)
  );
endmodule

// File: tb/tb_hbmc_tx_data_path.sv
// Scoreboard bench for hbmc_tx_data_path: directed bursts push expected words and
// done cycles; a monitor pops and compares whenever the DUT drives a word.
module tb_hbmc_tx_data_path;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [4:0]  lat_cycles = '0;
  logic [15:0] s_data = '0;
  logic [1:0]  s_strb = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  dq_rise, dq_fall;
  logic        rwds_rise, rwds_fall, dq_oe, rwds_oe, busy, done, underrun;
`ifdef HBMC_TX_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  hbmc_tx_data_path #(.LEN_WIDTH(8), .LAT_WIDTH(5)) dut (
    .clk(clk), .arst(arst), .start(start), .burst_len(burst_len), .lat_cycles(lat_cycles),
    .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .rwds_rise(rwds_rise), .rwds_fall(rwds_fall),
    .dq_oe(dq_oe), .rwds_oe(rwds_oe), .busy(busy), .done(done), .underrun(underrun)
`ifdef HBMC_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] r; logic [7:0] f; logic mr; logic mf; } exp_t;
  typedef struct { logic v; logic [15:0] d; logic [1:0] s; } src_t;
  exp_t exp_q[$];
  int   done_q[$];
  src_t src_q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic void exp_word(int c, logic [7:0] r, logic [7:0] f, logic mr, logic mf);
    exp_t e;
    e.c = c; e.r = r; e.f = f; e.mr = mr; e.mf = mf;
    exp_q.push_back(e);
  endfunction

  function automatic void src_word(logic v, logic [15:0] d, logic [1:0] s);
    src_t e;
    e.v = v; e.d = d; e.s = s;
    src_q.push_back(e);
  endfunction

  // Source: one queue entry per DATA cycle; an entry with v=0 is an underrun gap.
  initial begin
    logic rdy_s;
    forever begin
      @(negedge clk);
      rdy_s = s_ready;
      @(posedge clk);
      #1;
      if (rdy_s && src_q.size() > 0) begin
        if (src_q[0].v) hs_cnt++;
        void'(src_q.pop_front());
      end
      if (src_q.size() > 0) begin
        s_valid = src_q[0].v; s_data = src_q[0].d; s_strb = src_q[0].s;
      end else begin
        s_valid = 1'b0; s_data = '0; s_strb = '0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!arst) begin
      if (dq_oe) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'(dq_oe), 64'(0));
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_cycle", 64'(cyc), 64'(e.c));
          check("word_value", 64'({dq_rise, dq_fall, rwds_rise, rwds_fall, rwds_oe}),
                64'({e.r, e.f, e.mr, e.mf, 1'b1}));
        end
      end else begin
        check("idle_outputs", 64'({dq_rise, dq_fall, rwds_rise, rwds_fall, rwds_oe}), 64'(0));
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(done), 64'(0));
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  task automatic to_cycle(input int k);
    for (int i = 0; i < 1000 && cyc < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int k);
    to_cycle(k);
    #3;
  endtask

  task automatic pulse_start(input int len, input int lat, output int t);
    start = 1'b1; burst_len = 8'(len); lat_cycles = 5'(lat); t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic start_burst(input int len, input int lat, output int t);
    @(posedge clk);
    #1;
    pulse_start(len, lat, t);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(posedge clk);
    if (busy) check("busy_timeout", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t, t2, tx;
    // Reset state
    sample_at(2);
    check("reset_outputs", 64'({dq_rise, dq_fall, rwds_rise, rwds_fall, dq_oe, rwds_oe}), 64'(0));
    check("reset_ctrl", 64'({s_ready, busy, done, underrun}), 64'(0));
    @(posedge clk); #1; arst = 1'b0;

    // len=4, lat=6, full strobes
    src_word(1, 16'hA1B2, 2'b11); src_word(1, 16'hC3D4, 2'b11);
    src_word(1, 16'hE5F6, 2'b11); src_word(1, 16'h0718, 2'b11);
    start_burst(4, 6, t);
    exp_word(t+8, 8'hA1, 8'hB2, 0, 0); exp_word(t+9, 8'hC3, 8'hD4, 0, 0);
    exp_word(t+10, 8'hE5, 8'hF6, 0, 0); exp_word(t+11, 8'h07, 8'h18, 0, 0);
    done_q.push_back(t+11);
    sample_at(t+1);  check("busy_after_start", 64'(busy), 64'(1));
    sample_at(t+11); check("busy_at_done", 64'(busy), 64'(1));
    sample_at(t+12); check("busy_after_done", 64'(busy), 64'(0));
    wait_idle();

    // len=2, lat=0, partial strobes
    src_word(1, 16'h1122, 2'b10); src_word(1, 16'h3344, 2'b01);
    start_burst(2, 0, t);
    exp_word(t+2, 8'h11, 8'h22, 0, 1); exp_word(t+3, 8'h33, 8'h44, 1, 0);
    done_q.push_back(t+3);
    wait_idle();

    // len=3 with a gap on the 2nd DATA cycle
    hs_cnt = 0;
    src_word(1, 16'h1357, 2'b11); src_word(0, 16'hDEAD, 2'b11); src_word(1, 16'h2468, 2'b11);
    start_burst(3, 2, t);
    exp_word(t+4, 8'h13, 8'h57, 0, 0); exp_word(t+5, 8'h00, 8'h00, 1, 1);
    exp_word(t+6, 8'h24, 8'h68, 0, 0);
    done_q.push_back(t+6);
    wait_idle();
    check("underrun_sticky", 64'(underrun), 64'(1));
    check("handshakes", 64'(hs_cnt), 64'(2));
`ifdef HBMC_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", 64'(underrun_cnt), 64'(1));
`endif

    // Zero-length start ignored; start during LATENCY ignored
    start_burst(0, 3, t);
    sample_at(t+1); check("len0_no_busy", 64'({busy, s_ready}), 64'(0));
    check("len0_keeps_underrun", 64'(underrun), 64'(1));
    src_word(1, 16'hCAFE, 2'b11); src_word(1, 16'hBEEF, 2'b11);
    start_burst(2, 4, t);
    exp_word(t+6, 8'hCA, 8'hFE, 0, 0); exp_word(t+7, 8'hBE, 8'hEF, 0, 0);
    done_q.push_back(t+7);
    to_cycle(t+2);
    pulse_start(5, 0, tx);
    wait_idle();
    check("underrun_cleared", 64'(underrun), 64'(0));

    // Reset mid-DATA
    for (int i = 0; i < 8; i++) src_word(1, 16'(16'h4000 + i), 2'b11);
    start_burst(8, 0, t);
    exp_word(t+2, 8'h40, 8'h00, 0, 0);
    to_cycle(t+3);
    arst = 1'b1;
    src_q.delete(); exp_q.delete(); done_q.delete();
    #1;
    check("async_reset_outputs", 64'({dq_rise, dq_fall, rwds_rise, rwds_fall, dq_oe, rwds_oe}), 64'(0));
    check("async_reset_ctrl", 64'({s_ready, busy, done, underrun}), 64'(0));
    repeat (2) @(posedge clk);
    #1; arst = 1'b0;
    src_word(1, 16'h9A5C, 2'b11);
    start_burst(1, 1, t);
    exp_word(t+3, 8'h9A, 8'h5C, 0, 0);
    done_q.push_back(t+3);
    wait_idle();

    // Back-to-back: second start in the done cycle
    src_word(1, 16'h5566, 2'b11); src_word(0, 16'h0000, 2'b00);
    src_word(1, 16'h7788, 2'b11); src_word(1, 16'h99AA, 2'b01);
    start_burst(2, 0, t);
    exp_word(t+2, 8'h55, 8'h66, 0, 0); exp_word(t+3, 8'h00, 8'h00, 1, 1);
    done_q.push_back(t+3);
    sample_at(t+3);
    check("b2b_underrun_first", 64'(underrun), 64'(1));
    pulse_start(2, 1, t2);
    check("b2b_start_cycle", 64'(t2), 64'(t+3));
    exp_word(t+6, 8'h77, 8'h88, 0, 0); exp_word(t+7, 8'h99, 8'hAA, 1, 0);
    done_q.push_back(t+7);
    sample_at(t+4);
    check("b2b_busy_no_gap", 64'(busy), 64'(1));
    check("b2b_underrun_cleared", 64'(underrun), 64'(0));
    wait_idle();
`ifdef HBMC_TX_UNDERRUN_CNT_EN
    check("b2b_underrun_cnt", 64'(underrun_cnt), 64'(0));
`endif

    repeat (4) @(posedge clk);
    #1;
    check("exp_words_drained", 64'(exp_q.size()), 64'(0));
    check("exp_done_drained", 64'(done_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/hbmc_tx_data_path.md
Name: hbmc_tx_data_path

Overview:
- Transmit-side write-data path for the HyperBus controller; the counterpart of the read-side capture and elastic-buffer path.
- Runs entirely in the controller clock domain.
- After a programmable latency, pulls 16-bit write words and byte strobes from an upstream valid/ready source. Drives per-cycle DDR byte pairs, RWDS mask bits and output enables toward the IO/OSERDES stage.
- HyperBus cannot stall mid-burst, so an upstream underrun is handled by emitting a fully masked word.

Parameters:
- LEN_WIDTH, 8, width of burst length in 16-bit words.
- LAT_WIDTH, 5, width of latency cycle count.

Ports:
- clk  in  1  controller clock; all logic on posedge.
- arst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle burst request, honoured only when idle.
- burst_len  in  LEN_WIDTH  burst length in words, sampled with start.
- lat_cycles  in  LAT_WIDTH  idle clocks between start and first data, sampled with start.
- s_data  in  16  write word; [15:8] is the first (rising) byte.
- s_strb  in  2  byte enables; [1] covers [15:8].
- s_valid  in  1  upstream word valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- dq_rise  out  8  byte driven on rising half-cycle.
- dq_fall  out  8  byte driven on falling half-cycle.
- rwds_rise  out  1  mask for dq_rise; 1 = byte not written.
- rwds_fall  out  1  mask for dq_fall.
- dq_oe  out  1  DQ output enable.
- rwds_oe  out  1  RWDS output enable.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at end of burst.
- underrun  out  1  sticky: at least one masked filler word in the current or last burst.

Behaviour:
- Reset (arst high, any cycle including mid-burst):
  - State returns to IDLE.
  - dq_rise, dq_fall, rwds_rise, rwds_fall, dq_oe, rwds_oe, busy, done, underrun, s_ready all 0.
  - Counters cleared.
- States: IDLE, LATENCY, DATA.
- IDLE:
  - start=1 with burst_len!=0 latches len and lat, clears underrun, sets busy next cycle.
  - Next state is LATENCY if lat!=0, else DATA.
  - start with burst_len==0 is ignored: no busy, no done.
- LATENCY:
  - Down-counter loaded with lat, decrements each cycle.
  - Moves to DATA in the cycle the counter reaches 1, so it is held exactly lat cycles.
  - All outputs idle, oe low.
- DATA:
  - s_ready=1 combinationally from state, for exactly len cycles.
  - Every DATA cycle emits one word, registered, appearing on outputs the following cycle:
    - dq_rise=s_data[15:8], dq_fall=s_data[7:0]
    - rwds_rise=~s_strb[1], rwds_fall=~s_strb[0]
    - dq_oe=rwds_oe=1
  - If s_valid=0 in a DATA cycle:
    - Emit dq=0 with rwds_rise=rwds_fall=1 (filler word).
    - Set underrun.
    - Word counter still advances; no handshake occurs.
  - After the len-th DATA cycle, return to IDLE.
- End of burst: in the cycle the last word is on the outputs, done=1 for one cycle and busy drops the cycle after.
- Latency from start: first word on outputs at cycle T+1+lat+1, where T is the start cycle.
- Outside output-word cycles: dq/rwds outputs return to 0 and oe low.
- start while busy is ignored.
- Word counter is LEN_WIDTH bits and counts down. burst_len = 2^LEN_WIDTH-1 is the maximum burst; there is no wrap.
- A start coincident with the done cycle is accepted; busy stays high and there is no IDLE gap.

Optional Feature:
- Macro HBMC_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [7:0]. It counts filler words, saturates at 255, and clears on arst and on each accepted start.
- Undefined: port and counter are absent; the sticky underrun flag is unchanged.

Decomposition:
- Shared package hbmc_pkg holds:
  - state encoding (IDLE/LATENCY/DATA)
  - HBMC_RWDS_MASKED = 1'b1
  - byte-lane index constants (rise = [15:8])
- Natural sub-module: hbmc_tx_word_split, the registered word-to-DDR byte/mask mapper. It takes data, strb and a fill flag and produces dq_rise/dq_fall/rwds_*/oe.

Test Plan:
- start, len=4, lat=6, s_valid held 1, data 0xA1B2,0xC3D4,0xE5F6,0x0718 with strb=2'b11:
  - First dq_rise=0xA1 / dq_fall=0xB2 at T+8.
  - Four consecutive words, rwds=0.
  - done at T+11; busy low at T+12.
- len=2, lat=0, strb 2'b10 then 2'b01:
  - Data at T+2.
  - rwds_rise/fall = 0/1 then 1/0.
- len=3, s_valid dropped on the 2nd DATA cycle:
  - Middle output word is dq=0, rwds=11; underrun=1.
  - Only 2 handshakes.
  - done still at 3rd word.
  - With HBMC_TX_UNDERRUN_CNT_EN, underrun_cnt=1.
- start with burst_len=0, and start during LATENCY of an active burst: both ignored; no extra done, no change to the active burst.
- arst asserted mid-DATA of len=8 burst: all outputs 0 asynchronously; next start, len=1, lat=1 gives a correct single word at T+3.
- Back-to-back: second start in the done cycle of the first burst: busy stays 1 with no gap; underrun cleared for the new burst.
